// File: rtl/uartlite_scheduler_pkg.sv
// rtl/uartlite_scheduler_pkg.sv - register map, status bits and FSM encoding shared by the scheduler
package uartlite_scheduler_pkg;

   localparam logic [3:0] ADDR_RX_FIFO  = 4'h0;
   localparam logic [3:0] ADDR_TX_FIFO  = 4'h4;
   localparam logic [3:0] ADDR_STAT_REG = 4'h8;

   localparam int STAT_RX_VALID = 0;
   localparam int STAT_TX_FULL  = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STAT_AR = 3'd1,
      ST_STAT_R  = 3'd2,
      ST_RX_AR   = 3'd3,
      ST_RX_R    = 3'd4,
      ST_TX_W    = 3'd5,
      ST_TX_B    = 3'd6
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO; a push while full is rejected even if a pop lands the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_drop    = i_push && o_full;
   assign o_data    = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uartlite_scheduler.sv
// rtl/uartlite_scheduler.sv - polls a UART-Lite over AXI-Lite, drains RX bytes and feeds queued TX bytes
module uartlite_scheduler
   import uartlite_scheduler_pkg::*;
#(
   parameter int POLL_DIV  = 1000,
   parameter int TXQ_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_tx_push,
   input  logic [7:0]  i_tx_data,
   output logic        o_tx_full,
   output logic        o_tx_drop,
   output logic [7:0]  o_rx_data,
   output logic        o_rx_valid,
   output logic [3:0]  o_araddr,
   output logic        o_arvalid,
   input  logic        i_arready,
   input  logic [31:0] i_rdata,
   input  logic        i_rvalid,
   output logic        o_rready,
   output logic [3:0]  o_awaddr,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic [31:0] o_wdata,
   output logic        o_wvalid,
   input  logic        i_wready,
   input  logic        i_bvalid,
   output logic        o_bready
);

   localparam int PW = $clog2(POLL_DIV);

   state_t      r_state;
   state_t      w_next;
   logic [PW-1:0] r_poll_cnt;
   logic        r_aw_done;
   logic        r_w_done;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic [7:0]  w_head;
   logic        w_empty;
   logic        w_pop;
   logic        w_poll_hit;
   logic        w_unused_rdata;

   assign w_poll_hit     = (r_poll_cnt == PW'(POLL_DIV - 1));
   assign w_pop          = (r_state == ST_TX_B) && i_bvalid;
   assign w_unused_rdata = ^i_rdata[31:8];
   assign o_rx_data      = r_rx_data;
   assign o_rx_valid     = r_rx_valid;

   sync_fifo #(.WIDTH(8), .DEPTH(TXQ_DEPTH)) u_txq (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_tx_push),
      .i_data  (i_tx_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (o_tx_full),
      .o_empty (w_empty),
      .o_drop  (o_tx_drop)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // RX is checked before TX so a waiting receive byte is never starved by outgoing traffic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_poll_hit || !w_empty) w_next = ST_STAT_AR;
         ST_STAT_AR: if (i_arready) w_next = ST_STAT_R;
         ST_STAT_R:
            if (i_rvalid) begin
               if (i_rdata[STAT_RX_VALID])                  w_next = ST_RX_AR;
               else if (!i_rdata[STAT_TX_FULL] && !w_empty) w_next = ST_TX_W;
               else                                         w_next = ST_IDLE;
            end
         ST_RX_AR:   if (i_arready) w_next = ST_RX_R;
         ST_RX_R:    if (i_rvalid) w_next = ST_STAT_AR;
         ST_TX_W:    if ((r_aw_done || i_awready) && (r_w_done || i_wready)) w_next = ST_TX_B;
         ST_TX_B:    if (i_bvalid) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_araddr  = '0;
      o_arvalid = 1'b0;
      o_rready  = 1'b0;
      o_awaddr  = '0;
      o_awvalid = 1'b0;
      o_wdata   = '0;
      o_wvalid  = 1'b0;
      o_bready  = 1'b0;
      case (r_state)
         ST_STAT_AR: begin o_arvalid = 1'b1; o_araddr = ADDR_STAT_REG; end
         ST_RX_AR:   begin o_arvalid = 1'b1; o_araddr = ADDR_RX_FIFO; end
         ST_STAT_R,
         ST_RX_R:    o_rready = 1'b1;
         ST_TX_W: begin
            o_awaddr  = ADDR_TX_FIFO;
            o_awvalid = !r_aw_done;
            o_wdata   = {24'd0, w_head};
            o_wvalid  = !r_w_done;
         end
         ST_TX_B:    o_bready = 1'b1;
         default:    ;
      endcase
   end

   // Address and data channels complete independently; remember which already handshook.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_poll_cnt <= '0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_next == ST_IDLE) r_poll_cnt <= r_poll_cnt + PW'(1);
         else                                         r_poll_cnt <= '0;
         r_aw_done  <= (r_state == ST_TX_W) && (w_next == ST_TX_W) && (r_aw_done || i_awready);
         r_w_done   <= (r_state == ST_TX_W) && (w_next == ST_TX_W) && (r_w_done || i_wready);
         r_rx_valid <= (r_state == ST_RX_R) && i_rvalid;
         if (r_state == ST_RX_R && i_rvalid) r_rx_data <= i_rdata[7:0];
      end
   end

endmodule

// File: tb/tb_uartlite_scheduler.sv
// tb/tb_uartlite_scheduler.sv - directed self-checking bench for uartlite_scheduler
module tb_uartlite_scheduler;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_tx_push = 1'b0;
   logic [7:0]  i_tx_data = '0;
   logic        o_tx_full;
   logic        o_tx_drop;
   logic [7:0]  o_rx_data;
   logic        o_rx_valid;
   logic [3:0]  o_araddr;
   logic        o_arvalid;
   logic        i_arready = 1'b0;
   logic [31:0] i_rdata = '0;
   logic        i_rvalid = 1'b0;
   logic        o_rready;
   logic [3:0]  o_awaddr;
   logic        o_awvalid;
   logic        i_awready = 1'b0;
   logic [31:0] o_wdata;
   logic        o_wvalid;
   logic        i_wready = 1'b0;
   logic        i_bvalid = 1'b0;
   logic        o_bready;

   int n_checks = 0;
   int n_errors = 0;

   uartlite_scheduler #(.POLL_DIV(8), .TXQ_DEPTH(4)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_tx_push  (i_tx_push),
      .i_tx_data  (i_tx_data),
      .o_tx_full  (o_tx_full),
      .o_tx_drop  (o_tx_drop),
      .o_rx_data  (o_rx_data),
      .o_rx_valid (o_rx_valid),
      .o_araddr   (o_araddr),
      .o_arvalid  (o_arvalid),
      .i_arready  (i_arready),
      .i_rdata    (i_rdata),
      .i_rvalid   (i_rvalid),
      .o_rready   (o_rready),
      .o_awaddr   (o_awaddr),
      .o_awvalid  (o_awvalid),
      .i_awready  (i_awready),
      .o_wdata    (o_wdata),
      .o_wvalid   (o_wvalid),
      .i_wready   (i_wready),
      .i_bvalid   (i_bvalid),
      .o_bready   (o_bready)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] data);
      chk({tag, "_arvalid"}, 32'(o_arvalid), 32'd1);
      chk({tag, "_araddr"}, 32'(o_araddr), 32'(addr));
      i_arready = 1'b1;
      step();
      i_arready = 1'b0;
      chk({tag, "_rready"}, 32'(o_rready), 32'd1);
      i_rvalid = 1'b1;
      i_rdata  = data;
      step();
      i_rvalid = 1'b0;
      i_rdata  = '0;
   endtask

   initial begin
      step();
      step();
      chk("rst_arvalid", 32'(o_arvalid), 32'd0);
      chk("rst_rx_data", 32'(o_rx_data), 32'd0);
      chk("rst_tx_full", 32'(o_tx_full), 32'd0);
      chk("rst_bready", 32'(o_bready), 32'd0);
      i_reset = 1'b0;

      // idle polling every POLL_DIV cycles, no writes
      repeat (7) step();
      chk("poll1_early", 32'(o_arvalid), 32'd0);
      step();
      do_read("poll1", 4'h8, 32'h00);
      chk("poll1_idle_aw", 32'(o_awvalid), 32'd0);
      repeat (7) step();
      chk("poll2_early", 32'(o_arvalid), 32'd0);
      chk("poll2_no_write", 32'(o_awvalid | o_wvalid), 32'd0);
      step();

      // RX drain: STAT rx valid, byte read, immediate re-poll
      do_read("rx_stat", 4'h8, 32'h01);
      do_read("rx_data", 4'h0, 32'hFFFF_FF5A);
      chk("rx_valid_pulse", 32'(o_rx_valid), 32'd1);
      chk("rx_data", 32'(o_rx_data), 32'h5A);
      do_read("rx_restat", 4'h8, 32'h00);
      chk("rx_valid_low", 32'(o_rx_valid), 32'd0);
      chk("rx_data_held", 32'(o_rx_data), 32'h5A);

      // TX of two bytes, awready two cycles before wready
      i_tx_push = 1'b1; i_tx_data = 8'h41;
      step();
      i_tx_data = 8'h42;
      step();
      i_tx_push = 1'b0;
      do_read("tx1_stat", 4'h8, 32'h00);
      chk("tx1_awvalid", 32'(o_awvalid), 32'd1);
      chk("tx1_awaddr", 32'(o_awaddr), 32'h4);
      chk("tx1_wdata", o_wdata, 32'h41);
      i_awready = 1'b1;
      step();
      i_awready = 1'b0;
      chk("tx1_aw_dropped", 32'(o_awvalid), 32'd0);
      chk("tx1_w_held", 32'(o_wvalid), 32'd1);
      step();
      chk("tx1_w_held2", 32'(o_wvalid), 32'd1);
      i_wready = 1'b1;
      step();
      i_wready = 1'b0;
      chk("tx1_bready", 32'(o_bready), 32'd1);
      chk("tx1_w_done", 32'(o_wvalid), 32'd0);
      step();
      chk("tx1_b_stall", 32'(o_bready), 32'd1);
      i_bvalid = 1'b1;
      step();
      i_bvalid = 1'b0;
      step();
      do_read("tx2_stat", 4'h8, 32'h00);
      chk("tx2_wdata", o_wdata, 32'h42);
      i_awready = 1'b1; i_wready = 1'b1;
      step();
      i_awready = 1'b0; i_wready = 1'b0;
      chk("tx2_bready", 32'(o_bready), 32'd1);
      i_bvalid = 1'b1;
      step();
      i_bvalid = 1'b0;
      step();
      chk("tx2_queue_empty", 32'(o_arvalid), 32'd0);

      // fill queue while slave stalls, fifth push dropped
      i_tx_push = 1'b1; i_tx_data = 8'h10;
      step();
      i_tx_data = 8'h11;
      step();
      i_tx_data = 8'h12;
      step();
      i_tx_data = 8'h13;
      #1;
      chk("fill_no_drop", 32'(o_tx_drop), 32'd0);
      step();
      chk("fill_full", 32'(o_tx_full), 32'd1);
      i_tx_data = 8'hEE;
      #1;
      chk("fill_drop", 32'(o_tx_drop), 32'd1);
      step();
      i_tx_push = 1'b0;
      #1;
      chk("fill_drop_end", 32'(o_tx_drop), 32'd0);
      chk("fill_still_full", 32'(o_tx_full), 32'd1);
      do_read("full_stat", 4'h8, 32'h08);
      chk("full_no_aw", 32'(o_awvalid), 32'd0);
      step();
      chk("full_repoll", 32'(o_arvalid), 32'd1);
      chk("full_repoll_no_aw", 32'(o_awvalid), 32'd0);

      // pop and push in the same cycle while full: push rejected
      do_read("pp_stat", 4'h8, 32'h00);
      chk("pp_wdata", o_wdata, 32'h10);
      i_awready = 1'b1; i_wready = 1'b1;
      step();
      i_awready = 1'b0; i_wready = 1'b0;
      i_bvalid = 1'b1; i_tx_push = 1'b1; i_tx_data = 8'h99;
      #1;
      chk("pp_drop", 32'(o_tx_drop), 32'd1);
      step();
      i_bvalid = 1'b0; i_tx_push = 1'b0;
      #1;
      chk("pp_not_full", 32'(o_tx_full), 32'd0);
      step();
      do_read("rst_stat", 4'h8, 32'h00);
      chk("order_wdata", o_wdata, 32'h11);
      chk("pre_rst_awvalid", 32'(o_awvalid), 32'd1);

      // reset mid TX_W
      i_reset = 1'b1;
      #1;
      chk("rst_mid_awvalid", 32'(o_awvalid), 32'd0);
      chk("rst_mid_wvalid", 32'(o_wvalid), 32'd0);
      chk("rst_mid_wdata", o_wdata, 32'd0);
      chk("rst_mid_full", 32'(o_tx_full), 32'd0);
      chk("rst_mid_rx_data", 32'(o_rx_data), 32'd0);
      step();
      i_reset = 1'b0;
      repeat (7) step();
      chk("restart_early", 32'(o_arvalid), 32'd0);
      step();
      chk("restart_poll", 32'(o_arvalid), 32'd1);
      chk("restart_addr", 32'(o_araddr), 32'h8);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
